// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: walks DIGIT bits per clock MSB-first, chaining a G/L cascade.
// Optional macro SEQ_CMP_EARLY_EXIT_EN finishes as soon as the first differing digit decides the result.
module seq_mag_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int N     = WIDTH / DIGIT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {{(WIDTH-1){1'b0}}, 1'b1} << (WIDTH-1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   a_r, a_s, b_r, b_s;
    logic [IDX_W-1:0]   idx_r, idx_s;
    logic               g_r, g_s, l_r, l_s;
    logic               busy_r, busy_s, done_r, done_s;
    logic               gt_r, gt_s, lt_r, lt_s, eq_r, eq_s;
    logic [DIGIT-1:0]   da_s, db_s;
    logic               g_new_s, l_new_s, final_s;

    // Current digit pair and the cascade step applied to it.
    always_comb begin
        da_s    = a_r[int'(idx_r)*DIGIT +: DIGIT];
        db_s    = b_r[int'(idx_r)*DIGIT +: DIGIT];
        g_new_s = g_r | (~l_r & (da_s > db_s));
        l_new_s = l_r | (~g_r & (da_s < db_s));
`ifdef SEQ_CMP_EARLY_EXIT_EN
        final_s = (idx_r == IDX_W'(0)) | g_new_s | l_new_s;
`else
        final_s = (idx_r == IDX_W'(0));
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        b_s     = b_r;
        idx_s   = idx_r;
        g_s     = g_r;
        l_s     = l_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        gt_s    = gt_r;
        lt_s    = lt_r;
        eq_s    = eq_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    // Flipping both sign bits maps two's complement onto offset binary.
                    a_s     = signed_mode ? (a ^ MSB_MASK) : a;
                    b_s     = signed_mode ? (b ^ MSB_MASK) : b;
                    idx_s   = IDX_W'(N-1);
                    g_s     = 1'b0;
                    l_s     = 1'b0;
                    busy_s  = 1'b1;
                    gt_s    = 1'b0;
                    lt_s    = 1'b0;
                    eq_s    = 1'b0;
                    state_s = RUN;
                end else begin
                    busy_s = 1'b0;
                end
            end
            RUN: begin
                g_s = g_new_s;
                l_s = l_new_s;
                if (final_s) begin
                    gt_s    = g_new_s;
                    lt_s    = l_new_s;
                    eq_s    = ~(g_new_s | l_new_s);
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    idx_s = idx_r - IDX_W'(1);
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            idx_r   <= '0;
            g_r     <= 1'b0;
            l_r     <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
            eq_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            b_r     <= b_s;
            idx_r   <= idx_s;
            g_r     <= g_s;
            l_r     <= l_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            gt_r    <= gt_s;
            lt_r    <= lt_s;
            eq_r    <= eq_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign gt   = gt_r;
    assign lt   = lt_r;
    assign eq   = eq_r;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed self-checking bench for seq_mag_comparator (WIDTH=16, DIGIT=4).
module tb_seq_mag_comparator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    logic        signed_mode;
    logic        busy, done, gt, lt, eq;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SEQ_CMP_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    seq_mag_comparator #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .signed_mode(signed_mode), .busy(busy), .done(done),
        .gt(gt), .lt(lt), .eq(eq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flags are packed {gt,lt,eq}; lat_ee is the hand-derived early-exit latency.
    task automatic run_cmp(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                           input logic sm, input logic [2:0] exp_flags, input int lat_ee);
        int lat;
        a = ta; b = tb_v; signed_mode = sm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "/busy_at_start"}, 32'(busy), 32'd1);
        chk({tag, "/flags_cleared"}, 32'({gt, lt, eq}), 32'd0);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), EE ? 32'(lat_ee) : 32'd4);
        chk({tag, "/flags"}, 32'({gt, lt, eq}), 32'(exp_flags));
        chk({tag, "/busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic hold_check(input string tag, input logic [2:0] exp_flags);
        @(posedge clk); #1;
        chk({tag, "/done_drop"}, 32'(done), 32'd0);
        @(posedge clk); #1;
        chk({tag, "/held"}, 32'({gt, lt, eq}), 32'(exp_flags));
    endtask

    initial begin
        int lat;
        int done_seen;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/outputs", 32'({busy, done, gt, lt, eq}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Equality, signed/unsigned, cascade priority
        run_cmp("eq_1234", 16'h1234, 16'h1234, 1'b0, 3'b001, 4);
        hold_check("eq_1234", 3'b001);
        run_cmp("u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 3'b100, 1);
        hold_check("u_8000_7fff", 3'b100);
        run_cmp("s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 3'b010, 1);
        hold_check("s_8000_7fff", 3'b010);
        run_cmp("s_ffff_0001", 16'hFFFF, 16'h0001, 1'b1, 3'b010, 1);
        hold_check("s_ffff_0001", 3'b010);
        run_cmp("casc_00f0_00e1", 16'h00F0, 16'h00E1, 1'b0, 3'b100, 3);
        hold_check("casc_00f0_00e1", 3'b100);
        run_cmp("casc_0f00_1000", 16'h0F00, 16'h1000, 1'b0, 3'b010, 1);
        hold_check("casc_0f00_1000", 3'b010);

        // Early-exit latency vectors (full latency without the macro)
        run_cmp("ee_a000_1fff", 16'hA000, 16'h1FFF, 1'b0, 3'b100, 1);
        hold_check("ee_a000_1fff", 3'b100);
        run_cmp("ee_12f0_1200", 16'h12F0, 16'h1200, 1'b0, 3'b100, 3);
        hold_check("ee_12f0_1200", 3'b100);
        run_cmp("ee_beef", 16'hBEEF, 16'hBEEF, 1'b0, 3'b001, 4);
        hold_check("ee_beef", 3'b001);

        // Start while busy must be ignored
        a = 16'h0001; b = 16'h0002; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'h0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("busy_start/latency", 32'(lat), 32'd4);
        chk("busy_start/flags", 32'({gt, lt, eq}), 32'(3'b010));

        // Back-to-back: next start issued in the done cycle
        run_cmp("b2b_first", 16'h5555, 16'h5555, 1'b0, 3'b001, 4);
        run_cmp("b2b_second", 16'h0003, 16'h0002, 1'b0, 3'b100, 4);
        hold_check("b2b_second", 3'b100);

        // Asynchronous reset mid-run
        a = 16'h1234; b = 16'h1230; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst/outputs", 32'({busy, done, gt, lt, eq}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("midrst/no_done", 32'(done_seen), 32'd0);
        chk("midrst/flags_idle", 32'({busy, gt, lt, eq}), 32'd0);
        run_cmp("after_rst", 16'h4321, 16'h4322, 1'b0, 3'b010, 4);
        hold_check("after_rst", 3'b010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_mag_comparator.md
Name: seq_mag_comparator

Overview:
- Multi-cycle magnitude comparator for WIDTH-bit operands, signed or unsigned.
- Processes DIGIT bits per clock, MSB digit first.
- Carries a two-bit cascade state between digits (greater-so-far / less-so-far), the same way the bit-slice comparator chains C1/C0 into Z1/Z0.
- Used by the ALU compare/branch path where a full-width combinational comparator is too costly; start/done handshake.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT and at least DIGIT.
- DIGIT, 4, bits compared per clock; N = WIDTH/DIGIT compare cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a compare; sampled only when busy=0
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start
- busy  output  1  high while a compare is in progress
- done  output  1  one-cycle pulse when the result becomes valid
- gt  output  1  A > B (held)
- lt  output  1  A < B (held)
- eq  output  1  A == B (held)

Behaviour:
- Reset (async, rst_n=0): state IDLE, cascade cleared; busy, done, gt, lt, eq all 0. Takes effect immediately, including mid-operation; the in-flight compare is discarded and no done is produced.
- FSM states: IDLE, RUN.
- IDLE, start=1 at edge E0:
  - Latch a, b and signed_mode.
  - In signed mode, invert bit WIDTH-1 of both latched operands (offset-binary), so the unsigned digit compare gives the signed result.
  - Clear cascade (G=0, L=0), digit index = N-1, go to RUN. busy=1 from E0.
- RUN, at each edge, compare the current digit da/db (unsigned DIGIT-bit):
  - G' = G | (~L & da>db)
  - L' = L | (~G & da<db)
  - Decrement the index. G and L are never both 1.
- RUN, final digit (index 0):
  - At that edge (E_N): gt=G', lt=L', eq=~(G'|L'), done=1, busy=0, return to IDLE.
- done deasserts on the next edge. gt/lt/eq hold until the next accepted start, then clear to 0 at that start edge.
- Fixed latency: done is high in the cycle after edge E_N, exactly N edges after the start edge. Back-to-back: start may be asserted in the done cycle and is accepted at that edge.
- start while busy=1: ignored; operand inputs are don't-care while busy.
- Output flags are one-hot whenever done=1 or after any completed compare; all zero between reset and the first completion.
- WIDTH==DIGIT: N=1, single-cycle compare, done one edge after start.

Optional Feature:
- Macro: SEQ_CMP_EARLY_EXIT_EN.
- Defined: in RUN, as soon as G' or L' becomes 1 at an edge, that edge is treated as final: results registered, done=1, return to IDLE. Latency = 1-based position (from MSB) of the first differing digit. Equal operands still take N edges.
- Not defined: fixed N-edge latency as above; the cascade keeps running after decision with no effect on the result.

Test Plan (WIDTH=16, DIGIT=4, N=4):
1. Equal operands: a=0x1234, b=0x1234, signed_mode=0, start pulse → busy for 4 cycles; done exactly 4 edges after start; eq=1, gt=0, lt=0; flags held afterwards.
2. Signed vs unsigned: a=0x8000, b=0x7FFF. With signed_mode=0 → gt=1. Repeated with signed_mode=1 → lt=1. Also a=0xFFFF, b=0x0001, signed → lt=1.
3. Cascade priority: a=0x00F0, b=0x00E1 → gt=1, although the LSB digit alone says A<B. Also a=0x0F00, b=0x1000 → lt=1.
4. Handshake and reset:
   - Start accepted, second start with different operands 2 cycles later → ignored; first result reported.
   - Back-to-back start in the done cycle → accepted, next done 4 edges later.
   - rst_n pulsed low at cycle 2 of a run → all outputs 0 immediately, no done pulse; a fresh compare afterwards completes correctly.
5. Early exit (SEQ_CMP_EARLY_EXIT_EN defined):
   - a=0xA000, b=0x1FFF → done 1 edge after start, gt=1.
   - a=0x12F0, b=0x1200 → done after 3 edges, gt=1.
   - a=b=0xBEEF → done after 4 edges, eq=1.
   - Without the macro, all three cases complete in 4 edges.
